mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 101 ++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access stage behind the multi-cycle control FSM: address select, req/ack
// handshake with a variable-latency memory, IR/MDR capture, timeout and conflict faults.
//
// state  | meaning
// IDLE   | waiting for a single MemR or MemW strobe
// ACCESS | mem_req held high, waiting for mem_ack or timeout
// DONE   | one-cycle mem_done pulse, then back to IDLE
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemR,
  input  logic              MemW,
  input  logic              IoD,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       dst_ir;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      dst_ir    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MemR && MemW) begin
            mem_fault <= 1'b1;
          end else if (MemR ^ MemW) begin
            mem_addr  <= IoD ? alu_out : pc;
            mem_we    <= MemW;
            mem_wdata <= write_data;
            dst_ir    <= IRWrite;
            mem_req   <= 1'b1;
            mem_busy  <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // ack wins over a timeout landing on the same edge
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_busy <= 1'b0;
            mem_done <= 1'b1;
            state    <= S_DONE;
            if (!mem_we) begin
              if (dst_ir) ir  <= mem_rdata;
              else        mdr <= mem_rdata;
            end
          end else if (wait_cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            mem_busy  <= 1'b0;
            mem_fault <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_mem_access_unit;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              Reset, MemR, MemW, IoD, IRWrite, mem_ack;
  logic [DATA_W-1:0] pc, alu_out, write_data, mem_rdata;
  logic [DATA_W-1:0] mem_addr, mem_wdata, ir, mdr;
  logic              mem_req, mem_we, mem_busy, mem_done, mem_fault;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mem_access_unit #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .MemR(MemR), .MemW(MemW), .IoD(IoD), .IRWrite(IRWrite),
    .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .mdr(mdr),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_fault(mem_fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction, counted in edges waited for ack.
  logic [DATA_W-1:0] m_addr = '0, m_wdata = '0, m_ir = '0, m_mdr = '0;
  logic m_we = 0, m_req = 0, m_fault = 0, m_dst = 0, m_done = 0;
  int   m_wait = -1;

  always @(posedge CLK) begin
    if (Reset) begin
      m_addr = '0; m_wdata = '0; m_ir = '0; m_mdr = '0;
      m_we = 0; m_req = 0; m_fault = 0; m_dst = 0; m_done = 0; m_wait = -1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_wait >= 0) begin
      if (mem_ack) begin
        m_req = 0; m_done = 1; m_wait = -1;
        if (!m_we) begin
          if (m_dst) m_ir = mem_rdata;
          else       m_mdr = mem_rdata;
        end
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_req = 0; m_fault = 1; m_wait = -1;
        end
      end
    end else if (MemR && MemW) begin
      m_fault = 1;
    end else if (MemR != MemW) begin
      m_addr = IoD ? alu_out : pc;
      m_we = MemW; m_wdata = write_data; m_dst = IRWrite;
      m_req = 1; m_wait = 0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_addr",  32'(mem_addr),  32'(m_addr));
      chk("cyc_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("cyc_req",   32'(mem_req),   32'(m_req));
      chk("cyc_we",    32'(mem_we),    32'(m_we));
      chk("cyc_ir",    32'(ir),        32'(m_ir));
      chk("cyc_mdr",   32'(mdr),       32'(m_mdr));
      chk("cyc_busy",  32'(mem_busy),  32'(m_wait >= 0));
      chk("cyc_done",  32'(mem_done),  32'(m_done));
      chk("cyc_fault", 32'(mem_fault), 32'(m_fault));
    end
  end

  task automatic start(input logic r, input logic w, input logic iod, input logic irw);
    MemR = r; MemW = w; IoD = iod; IRWrite = irw;
    @(negedge CLK);
    MemR = 0; MemW = 0;
  endtask

  // Ack sampled at the lat-th rising edge after the strobe edge.
  task automatic ack_after(input int lat, input logic [DATA_W-1:0] d);
    repeat (lat - 1) @(negedge CLK);
    mem_ack = 1; mem_rdata = d;
    @(negedge CLK);
    mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    int bc, rc;
    Reset = 1; MemR = 0; MemW = 0; IoD = 0; IRWrite = 0; mem_ack = 0;
    pc = '0; alu_out = '0; write_data = '0; mem_rdata = '0;
    @(negedge CLK);
    chk_en = 1;
    @(negedge CLK);
    Reset = 0;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);

    // ack while idle is ignored
    mem_ack = 1; mem_rdata = 16'hFFFF;
    @(negedge CLK);
    mem_ack = 0; mem_rdata = '0;
    @(negedge CLK);
    chk("idle_ack_ir", 32'(ir), 32'd0);
    chk("idle_ack_mdr", 32'(mdr), 32'd0);

    // fetch
    pc = 16'h0010;
    start(1, 0, 0, 1);
    chk("fetch_addr", 32'(mem_addr), 32'h0010);
    chk("fetch_we", 32'(mem_we), 32'd0);
    chk("fetch_req", 32'(mem_req), 32'd1);
    ack_after(1, 16'h2010);
    chk("fetch_ir", 32'(ir), 32'h2010);
    chk("fetch_mdr", 32'(mdr), 32'd0);
    chk("fetch_done", 32'(mem_done), 32'd1);
    @(negedge CLK);
    chk("fetch_done_end", 32'(mem_done), 32'd0);

    // load with inputs changing mid-access
    alu_out = 16'h0100;
    bc = 0;
    start(1, 0, 1, 0);
    alu_out = 16'h7777; pc = 16'h9999; IRWrite = 1; MemW = 1;
    for (int i = 0; i < 8; i++) begin
      if (mem_busy) bc++;
      if (i == 3) begin mem_ack = 1; mem_rdata = 16'hBEEF; end
      else begin mem_ack = 0; mem_rdata = '0; end
      if (i == 5) MemW = 0;
      @(negedge CLK);
    end
    chk("load_busy_cycles", 32'(bc), 32'd4);
    chk("load_mdr", 32'(mdr), 32'hBEEF);
    chk("load_ir", 32'(ir), 32'h2010);

    // store
    alu_out = 16'h0200; write_data = 16'h1234; IRWrite = 0;
    start(0, 1, 1, 0);
    chk("store_we", 32'(mem_we), 32'd1);
    chk("store_wdata", 32'(mem_wdata), 32'h1234);
    chk("store_addr", 32'(mem_addr), 32'h0200);
    ack_after(2, 16'hDEAD);
    chk("store_done", 32'(mem_done), 32'd1);
    chk("store_ir", 32'(ir), 32'h2010);
    chk("store_mdr", 32'(mdr), 32'hBEEF);
    @(negedge CLK);

    // timeout
    pc = 16'h0040;
    start(1, 0, 0, 0);
    rc = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!mem_req) break;
      rc++;
    end
    chk("to_req_cycles", 32'(rc), 32'd15);
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_no_done", 32'(mem_done), 32'd0);
    @(negedge CLK);
    pc = 16'h0030;
    start(1, 0, 0, 1);
    ack_after(1, 16'h5555);
    chk("after_to_ir", 32'(ir), 32'h5555);
    chk("after_to_fault", 32'(mem_fault), 32'd1);
    @(negedge CLK);

    // reset mid-access, then a late ack
    start(1, 0, 1, 1);
    @(negedge CLK);
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_ir", 32'(ir), 32'd0);
    chk("midrst_mdr", 32'(mdr), 32'd0);
    chk("midrst_fault", 32'(mem_fault), 32'd0);
    mem_ack = 1; mem_rdata = 16'hABCD;
    @(negedge CLK);
    mem_ack = 0; mem_rdata = '0;
    chk("late_ack_ir", 32'(ir), 32'd0);

    // simultaneous read and write
    start(1, 1, 0, 0);
    chk("rw_req", 32'(mem_req), 32'd0);
    chk("rw_fault", 32'(mem_fault), 32'd1);
    chk("rw_busy", 32'(mem_busy), 32'd0);
    repeat (2) @(negedge CLK);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
